// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit with a small prefetch queue.
//
// The unit drives the instruction memory address from the fetch PC. On every
// rising edge where there is room in the queue, or where the decoder frees a
// slot, it captures {address, returned byte} into the queue tail. The decode
// stage reads the queue head through a valid/consume handshake. A redirect
// flushes the queue, discards the byte fetched in that cycle and reloads the
// fetch PC with the target.
//
// Parameters:
//   PROF_FILA  prefetch queue depth (power of 2, >= 2)
//   END_RESET  fetch address loaded on reset
//
// Ports:
//   clock           system clock, rising edge
//   reset           synchronous reset, active-high, highest priority
//   endereco        registered fetch PC driving the instruction memory
//   instrucao       memory byte for the current endereco
//   saida_valida    queue head is valid
//   saida_instr     instruction at the queue head (0 when not valid)
//   saida_pc        address of the queue head (0 when not valid)
//   consumir        decoder accepts the head this cycle
//   desvio          redirect request
//   destino_desvio  redirect target
//   ocupacao        current number of queued entries
//
// Optional feature (macro BUSCA_ESTATISTICAS_EN):
//   total_buscas     saturating count of pushes
//   total_descartes  saturating count of entries flushed by redirects
module unidade_busca #(
    parameter int         PROF_FILA = 4,
    parameter logic [7:0] END_RESET = 8'h00
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic [7:0]                  endereco,
    input  logic [7:0]                  instrucao,
    output logic                        saida_valida,
    output logic [7:0]                  saida_instr,
    output logic [7:0]                  saida_pc,
    input  logic                        consumir,
    input  logic                        desvio,
    input  logic [7:0]                  destino_desvio,
    output logic [$clog2(PROF_FILA):0]  ocupacao
`ifdef BUSCA_ESTATISTICAS_EN
    ,
    output logic [15:0]                 total_buscas,
    output logic [15:0]                 total_descartes
`endif
);

    localparam int             PTR_W = $clog2(PROF_FILA);
    localparam logic [PTR_W:0] CHEIO = (PTR_W + 1)'(PROF_FILA);

    logic [7:0]       pc_q, pc_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W:0]   cont_q, cont_d;
    logic [15:0]      fila_q [PROF_FILA];
    logic             pop;
    logic             emitir;

    // Handshake and next-state logic. A pop always frees a slot, so outside a
    // redirect every pop is accompanied by a push and the count only moves up
    // when pushing into a queue that is not being drained.
    always_comb begin
        pop    = (cont_q != '0) && consumir;
        emitir = !desvio && ((cont_q < CHEIO) || pop);
        pc_d   = pc_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cont_d = cont_q;
        if (desvio) begin
            pc_d   = destino_desvio;
            wr_d   = '0;
            rd_d   = '0;
            cont_d = '0;
        end else begin
            if (emitir) begin
                pc_d = pc_q + 8'd1;
                wr_d = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (emitir && !pop) begin
                cont_d = cont_q + (PTR_W + 1)'(1);
            end
        end
    end

    // Fetch PC, pointers and occupancy; reset overrides redirect and handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q   <= END_RESET;
            wr_q   <= '0;
            rd_q   <= '0;
            cont_q <= '0;
        end else begin
            pc_q   <= pc_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cont_q <= cont_d;
        end
    end

    // Queue storage needs no reset: an entry is only read once the count
    // says it has been written since the last flush.
    always_ff @(posedge clock) begin
        if (emitir) begin
            fila_q[wr_q] <= {pc_q, instrucao};
        end
    end

    always_comb begin
        endereco     = pc_q;
        ocupacao     = cont_q;
        saida_valida = (cont_q != '0);
        saida_pc     = saida_valida ? fila_q[rd_q][15:8] : 8'h00;
        saida_instr  = saida_valida ? fila_q[rd_q][7:0]  : 8'h00;
    end

`ifdef BUSCA_ESTATISTICAS_EN
    logic [15:0] buscas_q;
    logic [15:0] descartes_q;
    logic [16:0] soma_desc;

    // A head popped in the redirect cycle was accepted, so it is not a discard.
    always_comb begin
        soma_desc = {1'b0, descartes_q} + 17'(cont_q) - 17'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buscas_q    <= '0;
            descartes_q <= '0;
        end else begin
            if (emitir && (buscas_q != 16'hFFFF)) begin
                buscas_q <= buscas_q + 16'd1;
            end
            if (desvio) begin
                descartes_q <= soma_desc[16] ? 16'hFFFF : soma_desc[15:0];
            end
        end
    end

    assign total_buscas    = buscas_q;
    assign total_descartes = descartes_q;
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Testbench for unidade_busca (PROF_FILA=4, END_RESET=11).
// A queue-based reference model follows the fetch rules cycle by cycle and a
// compare process checks every DUT output against it on each falling edge.
// Directed scenarios add literal expectations for the key sequences.
module tb_unidade_busca;

    logic        clock;
    logic        reset;
    logic [7:0]  endereco;
    logic [7:0]  instrucao;
    logic        saida_valida;
    logic [7:0]  saida_instr;
    logic [7:0]  saida_pc;
    logic        consumir;
    logic        desvio;
    logic [7:0]  destino_desvio;
    logic [2:0]  ocupacao;
`ifdef BUSCA_ESTATISTICAS_EN
    logic [15:0] total_buscas;
    logic [15:0] total_descartes;
`endif

    int testes = 0;
    int falhas = 0;
    bit comparar = 0;

    logic [7:0] memoria [256];

    unidade_busca #(
        .PROF_FILA (4),
        .END_RESET (8'd11)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .endereco       (endereco),
        .instrucao      (instrucao),
        .saida_valida   (saida_valida),
        .saida_instr    (saida_instr),
        .saida_pc       (saida_pc),
        .consumir       (consumir),
        .desvio         (desvio),
        .destino_desvio (destino_desvio),
        .ocupacao       (ocupacao)
`ifdef BUSCA_ESTATISTICAS_EN
        ,
        .total_buscas    (total_buscas),
        .total_descartes (total_descartes)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instruction memory samples the address on the falling edge.
    always @(negedge clock) begin
        instrucao = memoria[endereco];
    end

    // Reference model: a queue of {pc, byte} pairs and a fetch address.
    logic [15:0] fila_m [$];
    logic [7:0]  pc_m = 8'd11;
    int          buscas_m = 0;
    int          descartes_m = 0;
    int          tam_m;
    bit          pop_m;

    always @(posedge clock) begin
        if (reset) begin
            fila_m.delete();
            pc_m        = 8'd11;
            buscas_m    = 0;
            descartes_m = 0;
        end else begin
            tam_m = fila_m.size();
            pop_m = (tam_m != 0) && consumir;
            if (desvio) begin
                descartes_m = descartes_m + tam_m - (pop_m ? 1 : 0);
                if (descartes_m > 65535) descartes_m = 65535;
                fila_m.delete();
                pc_m = destino_desvio;
            end else begin
                if (pop_m) void'(fila_m.pop_front());
                if (tam_m < 4 || pop_m) begin
                    fila_m.push_back({pc_m, memoria[pc_m]});
                    pc_m = pc_m + 8'd1;
                    if (buscas_m < 65535) buscas_m++;
                end
            end
        end
    end

    task automatic checkOutput(input string nome, input logic [15:0] atual,
                               input logic [15:0] esperado);
        testes++;
        if (atual !== esperado) begin
            falhas++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
        end
    endtask

    always @(negedge clock) begin
        if (comparar) begin
            checkOutput("m_endereco", 16'(endereco), 16'(pc_m));
            checkOutput("m_ocupacao", 16'(ocupacao), 16'(fila_m.size()));
            checkOutput("m_valida", 16'(saida_valida), 16'(fila_m.size() != 0));
            checkOutput("m_pc", 16'(saida_pc),
                        fila_m.size() != 0 ? 16'(fila_m[0][15:8]) : 16'h0);
            checkOutput("m_instr", 16'(saida_instr),
                        fila_m.size() != 0 ? 16'(fila_m[0][7:0]) : 16'h0);
`ifdef BUSCA_ESTATISTICAS_EN
            checkOutput("m_buscas", total_buscas, 16'(buscas_m));
            checkOutput("m_descartes", total_descartes, 16'(descartes_m));
`endif
        end
    end

    task automatic applyStimulus(input logic r, input logic c, input logic d,
                                 input logic [7:0] dest);
        reset          = r;
        consumir       = c;
        desvio         = d;
        destino_desvio = dest;
    endtask

    task automatic nextCycle();
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memoria[i] = 8'(i * 7 + 3);
        memoria[11] = 8'h1C;
        memoria[12] = 8'hE0;
        memoria[22] = 8'h00;
        memoria[34] = 8'hE3;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        nextCycle();
        nextCycle();

        // Reset state; this is also cycle 0 once reset drops.
        checkOutput("rst_endereco", 16'(endereco), 16'd11);
        checkOutput("rst_ocupacao", 16'(ocupacao), 16'd0);
        checkOutput("rst_valida", 16'(saida_valida), 16'd0);
        checkOutput("rst_instr", 16'(saida_instr), 16'd0);
        checkOutput("rst_pc", 16'(saida_pc), 16'd0);
        comparar = 1;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        // Streaming with consumir held high.
        nextCycle();
        checkOutput("c1_valida", 16'(saida_valida), 16'd1);
        checkOutput("c1_pc", 16'(saida_pc), 16'd11);
        checkOutput("c1_instr", 16'(saida_instr), 16'h1C);
        nextCycle();
        checkOutput("c2_pc", 16'(saida_pc), 16'd12);
        checkOutput("c2_instr", 16'(saida_instr), 16'hE0);
        nextCycle();
        checkOutput("c3_pc", 16'(saida_pc), 16'd13);

        // Fill the queue without consuming, then drain.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (6) nextCycle();
        checkOutput("full_ocupacao", 16'(ocupacao), 16'd4);
        checkOutput("full_endereco", 16'(endereco), 16'd15);
        checkOutput("full_head", 16'(saida_pc), 16'd11);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 12; k <= 15; k++) begin
            nextCycle();
            checkOutput("drain_head", 16'(saida_pc), 16'(k));
        end

        // Redirect with three entries queued.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) nextCycle();
        checkOutput("pre_desvio_ocup", 16'(ocupacao), 16'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd34);
        nextCycle();
        checkOutput("desvio_valida", 16'(saida_valida), 16'd0);
        checkOutput("desvio_ocup", 16'(ocupacao), 16'd0);
        checkOutput("desvio_endereco", 16'(endereco), 16'd34);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        nextCycle();
        checkOutput("alvo_pc", 16'(saida_pc), 16'd34);
        checkOutput("alvo_instr", 16'(saida_instr), 16'hE3);

        // Redirect near the top of the address space; PC wraps with no gap.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFE);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        nextCycle();
        checkOutput("wrap_FE", 16'(saida_pc), 16'h00FE);
        nextCycle();
        checkOutput("wrap_FF", 16'(saida_pc), 16'h00FF);
        nextCycle();
        checkOutput("wrap_00", 16'(saida_pc), 16'h0000);
        checkOutput("wrap_00_valida", 16'(saida_valida), 16'd1);
        nextCycle();
        checkOutput("wrap_01", 16'(saida_pc), 16'h0001);

        // Back-to-back redirects: the last target wins.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd40);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd50);
        nextCycle();
        checkOutput("duplo_endereco", 16'(endereco), 16'd50);
        checkOutput("duplo_ocup", 16'(ocupacao), 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        nextCycle();
        checkOutput("duplo_head", 16'(saida_pc), 16'd50);

`ifdef BUSCA_ESTATISTICAS_EN
        // Six pushes, then a redirect discarding four entries.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        nextCycle();
        checkOutput("est_rst_buscas", total_buscas, 16'd0);
        checkOutput("est_rst_desc", total_descartes, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (4) nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (2) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd22);
        nextCycle();
        checkOutput("est_buscas", total_buscas, 16'd6);
        checkOutput("est_descartes", total_descartes, 16'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        nextCycle();
`endif

        // Full queue with reset and redirect in the same cycle: reset wins.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (5) nextCycle();
        checkOutput("full2_ocup", 16'(ocupacao), 16'd4);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd22);
        nextCycle();
        checkOutput("rd_endereco", 16'(endereco), 16'd11);
        checkOutput("rd_ocupacao", 16'(ocupacao), 16'd0);
        checkOutput("rd_valida", 16'(saida_valida), 16'd0);
        checkOutput("rd_instr", 16'(saida_instr), 16'd0);
        checkOutput("rd_pc", 16'(saida_pc), 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        nextCycle();
        checkOutput("rd_after_pc", 16'(saida_pc), 16'd11);
        repeat (3) nextCycle();

        comparar = 0;
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
